// File: rtl/decoder_pipe.sv
// Flow-controlled instruction decode stage with a registered output slot.
// Define DECODER_PIPE_HAZARD_EN to build the read-after-write scoreboard interlock.
module decoder_pipe #(
   parameter int WIDTH      = 16,
   parameter int OP_WIDTH   = 4,
   parameter int REG_WIDTH  = 3,
   parameter int PEND_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 res,
   input  logic [WIDTH-1:0]     inst,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OP_WIDTH-1:0]  op,
   output logic [REG_WIDTH-1:0] lSel,
   output logic [REG_WIDTH-1:0] rSel,
   output logic [REG_WIDTH-1:0] oSel,
   output logic                 LOUT,
   output logic                 ROUT,
   output logic                 OIN,
   output logic                 CS,
   output logic                 RW,
   output logic [WIDTH-1:0]     r,
   output logic                 ill
);
   localparam int IM_W = WIDTH - OP_WIDTH - REG_WIDTH;

   localparam logic [OP_WIDTH-1:0] OP_NOP   = OP_WIDTH'(0);
   localparam logic [OP_WIDTH-1:0] OP_ADD   = OP_WIDTH'(1);
   localparam logic [OP_WIDTH-1:0] OP_SUB   = OP_WIDTH'(2);
   localparam logic [OP_WIDTH-1:0] OP_AND   = OP_WIDTH'(3);
   localparam logic [OP_WIDTH-1:0] OP_OR    = OP_WIDTH'(4);
   localparam logic [OP_WIDTH-1:0] OP_XOR   = OP_WIDTH'(5);
   localparam logic [OP_WIDTH-1:0] OP_LOADI = OP_WIDTH'(6);
   localparam logic [OP_WIDTH-1:0] OP_STORE = OP_WIDTH'(7);
   localparam logic [OP_WIDTH-1:0] OP_LOAD  = OP_WIDTH'(8);

   logic [OP_WIDTH-1:0]  f_op;
   logic [REG_WIDTH-1:0] f_rd, f_rs, f_rt;
   logic [IM_W-1:0]      f_im;

   // The immediate overlaps rs/rt; only LOADI interprets those bits as a constant.
   assign f_op = inst[WIDTH-1 -: OP_WIDTH];
   assign f_rd = inst[WIDTH-OP_WIDTH-1 -: REG_WIDTH];
   assign f_rs = inst[WIDTH-OP_WIDTH-REG_WIDTH-1 -: REG_WIDTH];
   assign f_rt = inst[WIDTH-OP_WIDTH-2*REG_WIDTH-1 -: REG_WIDTH];
   assign f_im = inst[IM_W-1:0];

   logic [REG_WIDTH-1:0] d_lsel, d_rsel, d_osel;
   logic                 d_lout, d_rout, d_oin, d_cs, d_rw, d_ill;
   logic [WIDTH-1:0]     d_imm;

   always_comb begin
      d_lsel = '0;
      d_rsel = '0;
      d_osel = '0;
      d_lout = 1'b0;
      d_rout = 1'b0;
      d_oin  = 1'b0;
      d_cs   = 1'b0;
      d_rw   = 1'b0;
      d_ill  = 1'b0;
      d_imm  = '0;
      case (f_op)
         OP_NOP: ;
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            d_lout = 1'b1; d_rout = 1'b1; d_oin = 1'b1;
            d_lsel = f_rs; d_rsel = f_rt; d_osel = f_rd;
         end
         OP_LOADI: begin
            d_oin  = 1'b1;
            d_osel = f_rd;
            d_imm  = {{(WIDTH-IM_W){f_im[IM_W-1]}}, f_im};
         end
         OP_STORE: begin
            d_lout = 1'b1; d_rout = 1'b1; d_cs = 1'b1;
            d_lsel = f_rd; d_rsel = f_rs; d_osel = f_rd;
         end
         OP_LOAD: begin
            d_lout = 1'b1; d_oin = 1'b1; d_cs = 1'b1; d_rw = 1'b1;
            d_lsel = f_rs; d_rsel = f_rt; d_osel = f_rd;
         end
         default: d_ill = 1'b1;
      endcase
   end

   logic advance, accept, hazard;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance && !hazard;
   assign accept   = in_valid && in_ready;

`ifdef DECODER_PIPE_HAZARD_EN
   // A writer stops interlocking as it reaches the oldest slot: its result is
   // written back that cycle, so only PEND_DEPTH-1 slots are actually held.
   localparam int SB_N = (PEND_DEPTH > 1) ? PEND_DEPTH - 1 : 1;

   logic [SB_N-1:0]                sb_vld;
   logic [SB_N-1:0][REG_WIDTH-1:0] sb_reg;
   logic [REG_WIDTH-1:0]           src_a, src_b;
   logic                           use_a, use_b, push;

   always_comb begin
      src_a = f_rs;
      src_b = f_rt;
      use_a = 1'b0;
      use_b = 1'b0;
      case (f_op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin use_a = 1'b1; use_b = 1'b1; end
         OP_STORE: begin src_a = f_rd; src_b = f_rs; use_a = 1'b1; use_b = 1'b1; end
         OP_LOAD:  use_a = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < SB_N; i++)
         if (sb_vld[i] && ((use_a && sb_reg[i] == src_a) || (use_b && sb_reg[i] == src_b)))
            hazard = 1'b1;
   end

   assign push = (PEND_DEPTH > 1) && accept && d_oin;

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         sb_vld <= '0;
         sb_reg <= '0;
      end else if (advance) begin
         for (int i = SB_N-1; i > 0; i--) begin
            sb_vld[i] <= sb_vld[i-1];
            sb_reg[i] <= sb_reg[i-1];
         end
         sb_vld[0] <= push;
         sb_reg[0] <= f_rd;
      end
   end
`else
   assign hazard = 1'b0;
`endif

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         out_valid <= 1'b0;
         op        <= '0;
         lSel      <= '0;
         rSel      <= '0;
         oSel      <= '0;
         LOUT      <= 1'b0;
         ROUT      <= 1'b0;
         OIN       <= 1'b0;
         CS        <= 1'b0;
         RW        <= 1'b0;
         r         <= '0;
         ill       <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         op        <= f_op;
         lSel      <= d_lsel;
         rSel      <= d_rsel;
         oSel      <= d_osel;
         LOUT      <= d_lout;
         ROUT      <= d_rout;
         OIN       <= d_oin;
         CS        <= d_cs;
         RW        <= d_rw;
         r         <= d_imm;
         ill       <= d_ill;
      end else if (advance) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decoder_pipe.sv
// Directed bench for decoder_pipe; interlock expectations follow DECODER_PIPE_HAZARD_EN.
module tb_decoder_pipe;
   logic        clk = 1'b0;
   logic        res;
   logic [15:0] inst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [3:0]  op;
   logic [2:0]  lSel, rSel, oSel;
   logic        LOUT, ROUT, OIN, CS, RW, ill;
   logic [15:0] r;

   int n_chk = 0;
   int n_err = 0;

   decoder_pipe #(.WIDTH(16), .OP_WIDTH(4), .REG_WIDTH(3), .PEND_DEPTH(2)) dut (
      .clk(clk), .res(res), .inst(inst), .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .op(op), .lSel(lSel), .rSel(rSel),
      .oSel(oSel), .LOUT(LOUT), .ROUT(ROUT), .OIN(OIN), .CS(CS), .RW(RW), .r(r), .ill(ill)
   );

   always #5 clk = ~clk;

   localparam logic [3:0] NOP = 4'd0, ADD = 4'd1, SUB = 4'd2, ORR = 4'd4, XOR = 4'd5,
                          LDI = 4'd6, STO = 4'd7, LD = 4'd8, BAD = 4'd15;

   function automatic logic [15:0] mk(input logic [3:0] o, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [2:0] rt);
      return {o, rd, rs, rt, 3'b000};
   endfunction

   function automatic logic [15:0] mki(input logic [2:0] rd, input logic [8:0] im);
      return {LDI, rd, im};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Packed views: strobes {LOUT,ROUT,OIN,CS,RW}; selects {lSel,rSel,oSel}.
   wire [4:0] strb = {LOUT, ROUT, OIN, CS, RW};
   wire [8:0] sels = {lSel, rSel, oSel};

   initial begin
      res = 1'b0; inst = '0; in_valid = 1'b0; out_ready = 1'b1;
      tick(); tick();
      chk("rst_vld",  {31'd0, out_valid}, 32'd0);
      chk("rst_fld",  {15'd0, op, sels, strb, ill}, 32'd0);
      chk("rst_r",    {16'd0, r}, 32'd0);
      res = 1'b1; #1;
      chk("rst_rdy",  {31'd0, in_ready}, 32'd1);

      // Producer ADD r3 = r1 op r2
      inst = mk(ADD, 3'd3, 3'd1, 3'd2); in_valid = 1'b1; #1;
      chk("add_rdy",  {31'd0, in_ready}, 32'd1);
      tick();
      chk("add_vld",  {31'd0, out_valid}, 32'd1);
      chk("add_sel",  {23'd0, sels}, {23'd0, 3'd1, 3'd2, 3'd3});
      chk("add_strb", {27'd0, strb}, 32'b11100);
      chk("add_r",    {16'd0, r}, 32'd0);

      // Consumer ADD r4 = r3 op r3
      inst = mk(ADD, 3'd4, 3'd3, 3'd3); #1;
`ifdef DECODER_PIPE_HAZARD_EN
      chk("dep_stall", {31'd0, in_ready}, 32'd0);
      tick();
      chk("dep_bubble", {31'd0, out_valid}, 32'd0);
      chk("dep_rdy",   {31'd0, in_ready}, 32'd1);
      tick();
`else
      chk("dep_rdy",   {31'd0, in_ready}, 32'd1);
      tick();
`endif
      chk("dep_vld",  {31'd0, out_valid}, 32'd1);
      chk("dep_sel",  {23'd0, sels}, {23'd0, 3'd3, 3'd3, 3'd4});

      // LOADI negative and positive immediates
      inst = mki(3'd5, 9'h1F0); tick();
      chk("ldi_neg_r",  {16'd0, r}, 32'h0000FFF0);
      chk("ldi_neg_st", {27'd0, strb}, 32'b00100);
      chk("ldi_neg_sl", {23'd0, sels}, {23'd0, 3'd0, 3'd0, 3'd5});
      inst = mki(3'd5, 9'h00F); tick();
      chk("ldi_pos_r",  {16'd0, r}, 32'h0000000F);

      // LOAD r2 <- [r6], then stall with a consumer of r2 waiting
      inst = mk(LD, 3'd2, 3'd6, 3'd7); #1;
      chk("ld_rdy", {31'd0, in_ready}, 32'd1);
      tick();
      out_ready = 1'b0; inst = mk(SUB, 3'd1, 3'd2, 3'd2); #1;
      for (int i = 0; i < 3; i++) begin
         chk("bp_rdy",  {31'd0, in_ready}, 32'd0);
         chk("bp_vld",  {31'd0, out_valid}, 32'd1);
         chk("bp_fld",  {19'd0, op, sels}, {19'd0, LD, 3'd6, 3'd7, 3'd2});
         chk("bp_strb", {27'd0, strb}, 32'b10111);
         tick();
      end
      out_ready = 1'b1; #1;
`ifdef DECODER_PIPE_HAZARD_EN
      chk("bp_frozen", {31'd0, in_ready}, 32'd0);
      tick();
      chk("bp_drain", {31'd0, out_valid}, 32'd0);
      chk("bp_rdy2",  {31'd0, in_ready}, 32'd1);
      tick();
`else
      chk("bp_rel_rdy", {31'd0, in_ready}, 32'd1);
      tick();
`endif
      chk("sub_vld", {31'd0, out_valid}, 32'd1);
      chk("sub_op",  {28'd0, op}, {28'd0, SUB});

      // Independent instruction: same-cycle drain and accept after a stall
      out_ready = 1'b0; inst = mk(ORR, 3'd6, 3'd0, 3'd0); #1;
      chk("or_stall", {31'd0, in_ready}, 32'd0);
      tick();
      chk("or_hold",  {28'd0, op}, {28'd0, SUB});
      out_ready = 1'b1; #1;
      chk("or_rdy",   {31'd0, in_ready}, 32'd1);
      tick();
      chk("or_fld",   {19'd0, op, sels}, {19'd0, ORR, 3'd0, 3'd0, 3'd6});
      chk("or_vld",   {31'd0, out_valid}, 32'd1);

      // Illegal opcode: passes through, no strobes, no scoreboard push
      inst = mk(BAD, 3'd3, 3'd1, 3'd2); tick();
      chk("ill_flag", {31'd0, ill}, 32'd1);
      chk("ill_strb", {27'd0, strb}, 32'd0);
      chk("ill_fld",  {19'd0, op, sels}, {19'd0, BAD, 9'd0});
      chk("ill_vld",  {31'd0, out_valid}, 32'd1);
      inst = mk(ADD, 3'd0, 3'd3, 3'd3); #1;
      chk("ill_nopush", {31'd0, in_ready}, 32'd1);
      tick();
      chk("ill_next", {29'd0, out_valid, ill, OIN}, 32'b101);

      // Reset mid-stream discards output and scoreboard
      inst = mki(3'd4, 9'd0); tick();
      in_valid = 1'b0; #2;
      res = 1'b0; #1;
      chk("mrst_vld", {31'd0, out_valid}, 32'd0);
      chk("mrst_fld", {15'd0, op, sels, strb, ill}, 32'd0);
      tick();
      res = 1'b1; inst = mk(ADD, 3'd1, 3'd4, 3'd4); in_valid = 1'b1; #1;
      chk("mrst_rdy", {31'd0, in_ready}, 32'd1);
      tick();
      chk("mrst_add", {23'd0, sels}, {23'd0, 3'd4, 3'd4, 3'd1});

      // STORE [r2] <- r3 and NOP
      inst = mk(STO, 3'd2, 3'd3, 3'd0); tick();
      chk("st_sel",  {23'd0, sels}, {23'd0, 3'd2, 3'd3, 3'd2});
      chk("st_strb", {27'd0, strb}, 32'b11010);
      inst = mk(NOP, 3'd7, 3'd7, 3'd7); tick();
      chk("nop_out", {25'd0, out_valid, strb, ill}, {25'd0, 1'b1, 5'd0, 1'b0});
      chk("nop_sel", {23'd0, sels}, 32'd0);

      in_valid = 1'b0; tick();
      chk("idle_vld", {31'd0, out_valid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
